// File: rtl/restador_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor controller.
// Latency: none (package only).
// Backpressure: none (package only).
package restador_pkg;

    localparam int STATE_W = 2;

    // IDLE/SHIFT/DONE codes are fixed; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bit counter must index 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/restador_serial_ctrl_if.sv
// Operand/result bundle between a requester and the serial subtractor.
// Latency: none (wiring only).
// Backpressure: start is only honoured while busy is low; no queueing.
interface restador_serial_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;
    logic [N-1:0] R;
    logic         AN;
    logic         Z;

    modport master (output start, X, Y, input busy, done, R, AN, Z);
    modport slave  (input start, X, Y, output busy, done, R, AN, Z);
endinterface

// File: rtl/restador_completo.sv
// Full subtractor built from two half subtractors and an OR on the borrows.
// Latency: combinational.
// Backpressure: none.
module restador_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    restador_medio u_hs0 (.i_a(i_a),  .i_b(i_b),   .o_d(w_d1), .o_bout(w_b1));
    restador_medio u_hs1 (.i_a(w_d1), .i_b(i_bin), .o_d(o_d),  .o_bout(w_b2));

    assign o_bout = w_b1 | w_b2;
endmodule

// File: rtl/restador_medio.sv
// Half subtractor cell: d = a - b, bout set when a borrow is needed.
// Latency: combinational.
// Backpressure: none.
module restador_medio (
    input  logic i_a,
    input  logic i_b,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b;
    assign o_bout = ~i_a & i_b;
endmodule

// File: rtl/restador_serial_ctrl.sv
// Bit-serial N-bit subtractor R = X - Y, one bit per clock, LSB first.
// Latency: done pulses N cycles after the accepting start edge; one op per N+2 cycles.
// Backpressure: start ignored while busy (SHIFT/DONE); requester must hold or retry.
module restador_serial_ctrl
    import restador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    restador_serial_ctrl_if.slave  bus
);
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_sx;
    logic [N-1:0]    r_sy;
    logic [N-2:0]    r_acc;
    logic            r_borrow;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_R;
    logic            r_AN;
    logic            r_Z;

    logic            w_d;
    logic            w_bout;
    logic            w_load;
    logic            w_shift;
    logic            w_last;
    logic [N-1:0]    w_cat;

    // Single cell consumes the current LSBs and the carried borrow.
    restador_completo u_cell (
        .i_a    (r_sx[0]),
        .i_b    (r_sy[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // New difference bit enters at the top; on the last bit this is the full result.
    assign w_cat = {w_d, r_acc};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath strobes; the unused code falls back to IDLE.
    always_comb begin
        w_next  = IDLE;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = DONE;
                    w_last = 1'b1;
                end else begin
                    w_next = SHIFT;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand shifters, borrow, counter, and the result registers updated only on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_R      <= '0;
            r_AN     <= 1'b0;
            r_Z      <= 1'b0;
        end else begin
            if (w_load) begin
                r_sx     <= bus.X;
                r_sy     <= bus.Y;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
            end else if (w_shift) begin
                r_sx     <= r_sx >> 1;
                r_sy     <= r_sy >> 1;
                r_acc    <= w_cat[N-1:1];
                r_borrow <= w_bout;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_R  <= w_cat;
                r_AN <= w_bout;
                r_Z  <= (w_cat == '0);
            end
        end
    end

    assign bus.busy = (r_state == SHIFT) || (r_state == DONE);
    assign bus.done = (r_state == DONE);
    assign bus.R    = r_R;
    assign bus.AN   = r_AN;
    assign bus.Z    = r_Z;

endmodule

// File: tb/tb_restador_serial_ctrl.sv
// Directed and random checks of the serial subtractor against a queued X-Y model.
// Latency: each op expected to complete N cycles after its accepting edge.
// Backpressure: starts issued while busy are expected to be dropped.
module tb_restador_serial_ctrl;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] r;
        logic         an;
        logic         z;
        int           acc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   done_cnt;
    exp_t exp_q[$];

    restador_serial_ctrl_if #(.N(N)) bus ();

    restador_serial_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] d;
        d = {1'b0, x} - {1'b0, y};
        exp_q.push_back('{d[N-1:0], d[N], (d[N-1:0] == '0), cyc});
    endtask

    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit expect_acc);
        @(negedge clk);
        bus.X     = x;
        bus.Y     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (expect_acc) push_exp(x, y);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every done must match the oldest expected result and latency.
    initial begin : monitor
        exp_t e;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                chk("unexpected_done", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("R",       bus.R,        e.r);
                    chk("AN",      bus.AN,       e.an);
                    chk("Z",       bus.Z,        e.z);
                    chk("latency", cyc - e.acc,  N);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dc0;
        int busy_n;
        logic [N-1:0] rx;
        logic [N-1:0] ry;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_R",    bus.R,    0);
        chk("rst_AN",   bus.AN,   0);
        chk("rst_Z",    bus.Z,    0);
        @(negedge clk);
        rst = 1'b0;

        // 5-3 with busy-window measurement
        start_op(8'h05, 8'h03, 1);
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy === 1'b1) busy_n++;
        end
        chk("busy_cycles", busy_n, 9);
        drain();

        start_op(8'h03, 8'h05, 1); drain();
        start_op(8'h00, 8'h01, 1); drain();
        start_op(8'hFF, 8'hFF, 1); drain();
        start_op(8'h80, 8'h00, 1); drain();

        // start during SHIFT is dropped
        dc0 = done_cnt;
        start_op(8'h05, 8'h03, 1);
        repeat (2) @(posedge clk);
        start_op(8'h10, 8'h01, 0);
        drain();
        repeat (15) @(negedge clk);
        #1;
        chk("single_done", done_cnt - dc0, 1);
        chk("R_hold_idle", bus.R, 8'h02);
        chk("idle_busy",   bus.busy, 0);

        // reset mid-SHIFT aborts without done
        dc0 = done_cnt;
        start_op(8'hA0, 8'h0A, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_R",    bus.R,    0);
        chk("abort_AN",   bus.AN,   0);
        chk("abort_Z",    bus.Z,    0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        start_op(8'hA0, 8'h0A, 1); drain();

        // start held high: accepts every N+2 cycles
        dc0 = done_cnt;
        @(negedge clk);
        bus.X     = 8'h07;
        bus.Y     = 8'h09;
        bus.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i % (N + 2) == 0) push_exp(8'h07, 8'h09);
        end
        bus.start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        #1;
        chk("held_done_count", done_cnt - dc0, 3);

        // random sweep
        for (int k = 0; k < 1000; k++) begin
            rx = N'($urandom);
            ry = N'($urandom);
            start_op(rx, ry, 1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
